// File: rtl/isa_pkg.sv
// Shared ISA definitions for the fetch and control stages: opcodes, branch
// encodings, instruction field positions and the loop counter width.
package isa_pkg;

  // Instruction word layout: opcode in the top three bits, operand below
  localparam int INSTR_W = 9;
  localparam int OPC_HI  = 8;
  localparam int OPC_LO  = 6;
  localparam int OPD_HI  = 5;
  localparam int OPD_LO  = 0;

  // Loop counter width equals the operand field width
  localparam int LOOP_W  = OPD_HI - OPD_LO + 1;

  // Opcodes
  localparam logic [2:0] OP_ALU   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_LDC   = 3'b011;
  localparam logic [2:0] OP_DJNZ  = 3'b100;
  localparam logic [2:0] OP_SRCH  = 3'b101;
  localparam logic [2:0] OP_NOP   = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // Next-PC selection seen by the fetch stage; code 3 is never produced
  localparam logic [1:0] BR_SEQ  = 2'd0;
  localparam logic [1:0] BR_BACK = 2'd1;
  localparam logic [1:0] BR_SKIP = 2'd2;

  // Control FSM states
  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_LOAD_WAIT = 2'd1,
    ST_HALTED    = 2'd2
  } state_t;

  // Bundle of decoded controls driven out of the control unit
  typedef struct packed {
    logic [1:0] branch;
    logic       halt;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
  } ctrl_t;

  // Opcode field extraction
  function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_HI:OPC_LO];
  endfunction

  // Operand field extraction
  function automatic logic [OPD_HI-OPD_LO:0] operand_of(input logic [INSTR_W-1:0] instr);
    return instr[OPD_HI:OPD_LO];
  endfunction

endpackage

// File: rtl/loop_counter.sv
// Loop counter: loadable register that decrements on request and never
// wraps below zero. Exposes the flags the DJNZ decode needs.
module loop_counter #(
  parameter int LOOP_W = isa_pkg::LOOP_W
) (
  input  logic              clk,
  input  logic              init,
  input  logic              load,
  input  logic              dec,
  input  logic [LOOP_W-1:0] load_val,
  output logic [LOOP_W-1:0] cnt,
  output logic              gt_one,
  output logic              is_zero
);

  // Counter register: reset, load, or saturating decrement (floor at 0)
  always_ff @(posedge clk) begin
    if (init) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && !is_zero) begin
      cnt <= cnt - LOOP_W'(1);
    end
  end

  assign is_zero = (cnt == '0);
  assign gt_one  = (cnt > LOOP_W'(1));

endmodule

// File: rtl/ctrl_unit.sv
// Control/decode stage next to fetch. Decodes the current instruction into
// fetch controls (Branch, Halt) and datapath enables with zero latency, and
// sequences the two-cycle load stall and the terminal halt.
module ctrl_unit #(
  parameter int LOOP_W = isa_pkg::LOOP_W
) (
  input  logic                        CLK,
  input  logic                        Init,
  input  logic [isa_pkg::INSTR_W-1:0] Instr,
  input  logic                        Match,
  output logic [1:0]                  Branch,
  output logic                        Halt,
  output logic                        RegWrite,
  output logic                        MemRead,
  output logic                        MemWrite,
  output logic [LOOP_W-1:0]           LoopCnt
);

  import isa_pkg::*;

  state_t            state;
  state_t            state_nxt;
  ctrl_t             ctrl;
  logic [2:0]        opcode;
  logic [LOOP_W-1:0] operand;
  logic              cnt_load;
  logic              cnt_dec;
  logic              cnt_gt_one;
  logic              cnt_is_zero;

  assign opcode  = opcode_of(Instr);
  assign operand = LOOP_W'(operand_of(Instr));

  // State register; Init wins over every state including HALTED
  always_ff @(posedge CLK) begin
    if (Init) begin
      state <= ST_RUN;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: LOAD stalls for one extra cycle, HALT is terminal
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (opcode == OP_LOAD) begin
          state_nxt = ST_LOAD_WAIT;
        end else if (opcode == OP_HALT) begin
          state_nxt = ST_HALTED;
        end
      end
      ST_LOAD_WAIT: state_nxt = ST_RUN;
      ST_HALTED:    state_nxt = ST_HALTED;
      default:      state_nxt = ST_RUN;
    endcase
  end

  // Mealy output decode; everything is quiet while Init is held so the
  // fetch stage's own reset handling is not disturbed
  always_comb begin
    ctrl     = '0;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    if (!Init) begin
      case (state)
        ST_RUN: begin
          case (opcode)
            OP_ALU:   ctrl.reg_write = 1'b1;
            OP_LOAD: begin
              ctrl.mem_read = 1'b1;
              ctrl.halt     = 1'b1;
            end
            OP_STORE: ctrl.mem_write = 1'b1;
            OP_LDC:   cnt_load = 1'b1;
            OP_DJNZ: begin
              // The counter saturates at 0 itself; branch back only while
              // more than one pass remains
              cnt_dec = 1'b1;
              if (cnt_gt_one) begin
                ctrl.branch = BR_BACK;
              end
            end
            OP_SRCH: begin
              if (Match) begin
                ctrl.branch = BR_SKIP;
              end
            end
            OP_HALT:  ctrl.halt = 1'b1;
            default:  ctrl = '0;
          endcase
        end
        ST_LOAD_WAIT: begin
          // PC is still on the LOAD; complete it by writing the read data
          ctrl.mem_read  = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        ST_HALTED: ctrl.halt = 1'b1;
        default:   ctrl = '0;
      endcase
    end
  end

  loop_counter #(
    .LOOP_W (LOOP_W)
  ) u_loop_counter (
    .clk      (CLK),
    .init     (Init),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (operand),
    .cnt      (LoopCnt),
    .gt_one   (cnt_gt_one),
    .is_zero  (cnt_is_zero)
  );

  assign Branch   = ctrl.branch;
  assign Halt     = ctrl.halt;
  assign RegWrite = ctrl.reg_write;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;

endmodule

// File: tb/tb_ctrl_unit.sv
// Bench for ctrl_unit: directed sequences plus randomized instruction
// streams, scored against a cycle-level behavioural model of the ISA.
module tb_ctrl_unit;

  logic       clk;
  logic       init;
  logic [8:0] instr;
  logic       match;
  logic [1:0] branch;
  logic       halt;
  logic       reg_write;
  logic       mem_read;
  logic       mem_write;
  logic [5:0] loop_cnt;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string      name;
    logic [1:0] br;
    logic       halt;
    logic       rw;
    logic       mr;
    logic       mw;
    logic [5:0] cnt;
    bit         chk_cnt;
  } exp_t;

  exp_t q[$];

  // Model state: what the machine is doing, described in ISA terms
  int m_cnt     = 0;
  bit m_halted  = 0;
  bit m_wait    = 0;
  bit m_known   = 0;

  ctrl_unit #(.LOOP_W(6)) dut (
    .CLK      (clk),
    .Init     (init),
    .Instr    (instr),
    .Match    (match),
    .Branch   (branch),
    .Halt     (halt),
    .RegWrite (reg_write),
    .MemRead  (mem_read),
    .MemWrite (mem_write),
    .LoopCnt  (loop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one instruction for one cycle and record what must come out
  task automatic step(input string nm, input logic [8:0] ins, input logic mt, input logic ini);
    exp_t e;
    logic [2:0] op;
    op = ins[8:6];
    e.name = nm; e.br = 2'd0; e.halt = 1'b0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
    e.cnt = 6'(m_cnt); e.chk_cnt = m_known;
    if (!ini) begin
      if (m_halted) e.halt = 1'b1;
      else if (m_wait) begin e.mr = 1'b1; e.rw = 1'b1; end
      else begin
        case (op)
          3'd0: e.rw = 1'b1;
          3'd1: begin e.mr = 1'b1; e.halt = 1'b1; end
          3'd2: e.mw = 1'b1;
          3'd4: e.br = (m_cnt > 1) ? 2'd1 : 2'd0;
          3'd5: e.br = mt ? 2'd2 : 2'd0;
          3'd7: e.halt = 1'b1;
          default: ;
        endcase
      end
    end
    q.push_back(e);
    instr = ins; match = mt; init = ini;
    @(posedge clk);
    if (ini) begin
      m_cnt = 0; m_halted = 0; m_wait = 0; m_known = 1;
    end else if (!m_halted) begin
      if (m_wait) m_wait = 0;
      else begin
        case (op)
          3'd1: m_wait = 1;
          3'd3: m_cnt = int'(ins[5:0]);
          3'd4: if (m_cnt > 0) m_cnt = m_cnt - 1;
          3'd7: m_halted = 1;
          default: ;
        endcase
      end
    end
    #1;
  endtask

  // Monitor: compare DUT outputs mid-cycle against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        if (branch !== e.br || halt !== e.halt || reg_write !== e.rw ||
            mem_read !== e.mr || mem_write !== e.mw ||
            (e.chk_cnt && loop_cnt !== e.cnt)) begin
          failures++;
          $display("FAIL %s: got br=%0d halt=%0b rw=%0b mr=%0b mw=%0b cnt=%0d, expected br=%0d halt=%0b rw=%0b mr=%0b mw=%0b cnt=%0d (cnt checked=%0b)",
                   e.name, branch, halt, reg_write, mem_read, mem_write, loop_cnt,
                   e.br, e.halt, e.rw, e.mr, e.mw, e.cnt, e.chk_cnt);
        end
      end
    end
  end

  initial begin
    logic [2:0] op;
    logic [8:0] ins;
    init = 1'b1; instr = 9'b111_000000; match = 1'b0;
    @(posedge clk); #1;

    step("reset", 9'b111_000000, 1'b0, 1'b1);
    step("alu_after_reset", 9'b000_000000, 1'b0, 1'b0);

    step("ldc3", 9'b011_000011, 1'b0, 1'b0);
    step("djnz_a", 9'b100_000000, 1'b0, 1'b0);
    step("djnz_b", 9'b100_000000, 1'b0, 1'b0);
    step("djnz_c", 9'b100_000000, 1'b0, 1'b0);
    step("djnz_floor", 9'b100_000000, 1'b1, 1'b0);
    step("djnz_floor2", 9'b100_000000, 1'b0, 1'b0);

    step("srch_match", 9'b101_010101, 1'b1, 1'b0);
    step("srch_nomatch", 9'b101_010101, 1'b0, 1'b0);
    step("alu_match", 9'b000_111111, 1'b1, 1'b0);

    step("load_c1", 9'b001_000100, 1'b0, 1'b0);
    step("load_c2", 9'b001_000100, 1'b1, 1'b0);
    step("alu_after_load", 9'b000_000001, 1'b0, 1'b0);
    step("store", 9'b010_000001, 1'b1, 1'b0);
    step("nop", 9'b110_000001, 1'b1, 1'b0);

    step("ldc1", 9'b011_000001, 1'b0, 1'b0);
    step("djnz_one", 9'b100_000000, 1'b0, 1'b0);

    step("halt", 9'b111_000000, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("halted_hold", 9'($urandom), 1'($urandom), 1'b0);
    step("init_from_halt", 9'($urandom), 1'($urandom), 1'b1);
    step("alu_after_halt", 9'b000_000000, 1'b0, 1'b0);

    step("ldc5", 9'b011_000101, 1'b0, 1'b0);
    step("load_c1b", 9'b001_000000, 1'b0, 1'b0);
    step("init_mid_load", 9'b001_000000, 1'b0, 1'b1);
    step("load_after_init", 9'b001_000000, 1'b0, 1'b0);
    step("load_after_init_c2", 9'b001_000000, 1'b0, 1'b0);
    step("djnz_cnt_cleared", 9'b100_000000, 1'b0, 1'b0);

    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd7 && ($urandom % 3) != 0) op = 3'd6;
      ins = {op, 6'($urandom_range(0, 7))};
      if (($urandom % 4) == 0) ins[5:0] = 6'($urandom);
      step("random", ins, 1'($urandom), ($urandom % 40) == 0);
    end

    // Every pushed expectation must have been consumed by the monitor
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
